camera_capture: RTL

- Receiver for the parallel camera bus (vsync / href / 10-bit pixel) driven by the camera model or a real sensor.
- Registers the bus, frames pixels into row/column positions and checks frame geometry against ROWS x COLS.
- Buffers pixels in a small FIFO and presents them on a valid/ready stream with start-of-frame and end-of-line markers for downstream image logic.

---
 rtl/camera_capture.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/camera_capture.sv
// camera_capture: parallel camera bus receiver with frame geometry check and output FIFO.
// Optional completed-frame counter is built when CAMERA_CAPTURE_STATS_EN is defined.
module camera_capture #(
    parameter int          DATA_W     = 10,
    parameter logic [11:0] ROWS       = 12'd480,
    parameter logic [11:0] COLS       = 12'd640,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] image,
    input  logic              href,
    input  logic              vsync,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_done,
    output logic              frame_err,
    output logic              overflow,
    output logic [15:0]       frame_count
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          EW      = DATA_W + 2;
    localparam logic [AW:0] LP_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_FRAME
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_image_s1;
    logic                r_href_s1;
    logic                r_href_s2;
    logic                r_vsync_s1;
    logic                r_vsync_s2;
    logic [11:0]         r_row;
    logic [11:0]         r_col;
    logic                r_frame_done;
    logic                r_frame_err;
    logic                r_overflow;
    logic [EW-1:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr;
    logic [AW-1:0]       r_rd;
    logic [AW:0]         r_count;

    logic                w_vrise;
    logic                w_fall;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_wr;
    logic                w_drop;
    logic                w_sof;
    logic                w_eol;
    logic [11:0]         w_row_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_image_s1 <= '0;
            r_href_s1  <= 1'b0;
            r_href_s2  <= 1'b0;
            r_vsync_s1 <= 1'b0;
            r_vsync_s2 <= 1'b0;
        end else begin
            r_image_s1 <= image;
            r_href_s1  <= href;
            r_href_s2  <= r_href_s1;
            r_vsync_s1 <= vsync;
            r_vsync_s2 <= r_vsync_s1;
        end
    end

    assign w_vrise   = r_vsync_s1 && !r_vsync_s2;
    assign w_fall    = r_href_s2 && !r_href_s1;
    assign w_row_nxt = r_row + 12'd1;
    assign w_sof     = (r_row == 12'd0) && (r_col == 12'd0);
    assign w_eol     = (r_col == COLS - 12'd1);
    // An over-long row is rejected at the first pixel past COLS.
    assign w_push    = (r_state == S_FRAME) && !w_vrise && r_href_s1 && (r_col != COLS);
    assign w_pop     = (r_count != '0) && out_ready;
    assign w_full    = (r_count == LP_FULL);
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_drop) r_overflow <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (w_vrise) r_state <= S_SYNC;
                end
                S_SYNC: begin
                    if (!r_vsync_s1) begin
                        r_state    <= S_FRAME;
                        r_row      <= '0;
                        r_col      <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                S_FRAME: begin
                    if (w_vrise) begin
                        r_frame_err <= 1'b1;
                        r_state     <= S_SYNC;
                    end else if (r_href_s1) begin
                        if (r_col == COLS) begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_col <= r_col + 12'd1;
                        end
                    end else if (w_fall) begin
                        if (r_col != COLS) begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_row <= w_row_nxt;
                            r_col <= '0;
                            if (w_row_nxt == ROWS) begin
                                r_frame_done <= 1'b1;
                                r_state      <= S_IDLE;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr] <= {w_sof, w_eol, r_image_s1};
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_data   = r_mem[r_rd][DATA_W-1:0];
    assign out_eol    = r_mem[r_rd][DATA_W];
    assign out_sof    = r_mem[r_rd][DATA_W+1];
    assign out_valid  = (r_count != '0);
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;

`ifdef CAMERA_CAPTURE_STATS_EN
    logic [15:0] r_frame_count;
    logic        w_fin;

    // Same condition that raises frame_done; a lossy frame is not counted.
    assign w_fin = (r_state == S_FRAME) && !w_vrise && w_fall
                   && (r_col == COLS) && (w_row_nxt == ROWS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_count <= '0;
        end else if (w_fin && !r_overflow) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`else
    assign frame_count = '0;
`endif

endmodule
